// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART core.
//   FRAME_DATA_BITS : data bits per frame (8N1 framing)
//   STOP_LEVEL      : line level of the stop bit (and of the idle line)
//   tx_state_e      : transmitter FSM states
//   rx_state_e      : receiver FSM states
//   calc_div()      : clocks per bit for a given clock / baud pair
package uart_pkg;

  localparam int FRAME_DATA_BITS = 8;
  localparam logic STOP_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Integer clocks-per-bit; callers rely on the result being >= 4.
  function automatic int calc_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_if.sv
// uart_if -- signal bundle between the UART core and its user.
//   tx_data/tx_send       : byte + single-cycle transmit request
//   tx/tx_busy            : serial output and transmitter busy flag
//   rx                    : serial input (asynchronous to clk)
//   rx_data/rx_ready      : received byte + one-cycle valid pulse
//   baud_tick             : one-cycle pulse per bit period
//   rx_frame_err          : stop-bit error pulse, only when UART_FRAME_ERR_EN is defined
// Modports: master = user side, slave = uart_core side.
interface uart_if;
  import uart_pkg::*;

  logic [FRAME_DATA_BITS-1:0] tx_data;
  logic                       tx_send;
  logic                       tx;
  logic                       tx_busy;
  logic                       rx;
  logic [FRAME_DATA_BITS-1:0] rx_data;
  logic                       rx_ready;
  logic                       baud_tick;
`ifdef UART_FRAME_ERR_EN
  logic                       rx_frame_err;
`endif

  modport master (
    output tx_data, tx_send, rx,
    input  tx, tx_busy, rx_data, rx_ready, baud_tick
`ifdef UART_FRAME_ERR_EN
    , input rx_frame_err
`endif
  );

  modport slave (
    input  tx_data, tx_send, rx,
    output tx, tx_busy, rx_data, rx_ready, baud_tick
`ifdef UART_FRAME_ERR_EN
    , output rx_frame_err
`endif
  );

endinterface

// File: rtl/uart_tick_gen.sv
// uart_tick_gen -- free-running baud divider.
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset
//   baud_tick : registered one-cycle pulse while the counter sits at DIV-1
// DIV = CLK_FREQ / BAUD_RATE must be at least 4.
module uart_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic clk,
  input  logic reset,
  output logic baud_tick
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DIV - 2);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             tick_r;
  logic             tick_s;

  // Next count and tick; the tick is decoded one count early so the
  // registered pulse lines up with the cycle the counter equals DIV-1.
  always_comb begin
    cnt_s  = cnt_r;
    tick_s = 1'b0;
    if (cnt_r == CNT_LAST) begin
      cnt_s = '0;
    end else begin
      cnt_s = cnt_r + CNT_W'(1);
    end
    if (cnt_r == CNT_PRE) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // Counter and tick registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_s;
      tick_r <= tick_s;
    end
  end

  assign baud_tick = tick_r;

endmodule

// File: rtl/uart_core.sv
// uart_core -- 8N1 UART transmitter and receiver sharing one baud divider.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : uart_if.slave (tx_data, tx_send, tx, tx_busy, rx, rx_data,
//           rx_ready, baud_tick, and rx_frame_err when UART_FRAME_ERR_EN is defined)
// TX steps one bit per baud_tick. RX has its own bit timer started on a
// synchronized falling edge and samples at bit midpoints.
// Optional feature macro: UART_FRAME_ERR_EN (adds rx_frame_err).
module uart_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000,
  parameter int BAUD_RATE = 9600
) (
  input logic  clk,
  input logic  reset,
  uart_if.slave bus
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int TMR_W = $clog2(DIV);
  localparam int BIT_W = $clog2(FRAME_DATA_BITS);
  localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(DIV / 2 - 1);
  localparam logic [TMR_W-1:0] TMR_FULL = TMR_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_DATA_BITS - 1);

  logic tick_s;

  uart_tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) u_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .baud_tick(tick_s)
  );

  // ---------------------------------------------------------------- TX
  tx_state_e                  tx_state_r, tx_state_s;
  logic [FRAME_DATA_BITS-1:0] tx_shift_r, tx_shift_s;
  logic [BIT_W-1:0]           tx_bit_r,   tx_bit_s;
  logic                       tx_line_r,  tx_line_s;
  logic                       tx_busy_r,  tx_busy_s;

  // TX next state: accept only while not busy, then move one bit per tick.
  always_comb begin
    tx_state_s = tx_state_r;
    tx_shift_s = tx_shift_r;
    tx_bit_s   = tx_bit_r;
    tx_line_s  = tx_line_r;
    tx_busy_s  = tx_busy_r;
    case (tx_state_r)
      TX_IDLE: begin
        if (!tx_busy_r) begin
          if (bus.tx_send) begin
            tx_shift_s = bus.tx_data;
            tx_busy_s  = 1'b1;
          end else begin
            tx_busy_s  = 1'b0;
          end
        end else if (tick_s) begin
          tx_state_s = TX_START;
          tx_line_s  = 1'b0;
        end else begin
          tx_state_s = TX_IDLE;
        end
      end
      TX_START: begin
        if (tick_s) begin
          tx_state_s = TX_DATA;
          tx_bit_s   = '0;
          tx_line_s  = tx_shift_r[0];
        end else begin
          tx_state_s = TX_START;
        end
      end
      TX_DATA: begin
        if (tick_s) begin
          if (tx_bit_r == BIT_LAST) begin
            tx_state_s = TX_STOP;
            tx_line_s  = STOP_LEVEL;
          end else begin
            tx_shift_s = {1'b0, tx_shift_r[FRAME_DATA_BITS-1:1]};
            tx_line_s  = tx_shift_r[1];
            tx_bit_s   = tx_bit_r + BIT_W'(1);
          end
        end else begin
          tx_state_s = TX_DATA;
        end
      end
      TX_STOP: begin
        if (tick_s) begin
          tx_state_s = TX_IDLE;
          tx_busy_s  = 1'b0;
          tx_line_s  = STOP_LEVEL;
        end else begin
          tx_state_s = TX_STOP;
        end
      end
      default: begin
        tx_state_s = TX_IDLE;
        tx_busy_s  = 1'b0;
        tx_line_s  = STOP_LEVEL;
      end
    endcase
  end

  // TX state and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_r <= TX_IDLE;
      tx_shift_r <= '0;
      tx_bit_r   <= '0;
      tx_line_r  <= 1'b1;
      tx_busy_r  <= 1'b0;
    end else begin
      tx_state_r <= tx_state_s;
      tx_shift_r <= tx_shift_s;
      tx_bit_r   <= tx_bit_s;
      tx_line_r  <= tx_line_s;
      tx_busy_r  <= tx_busy_s;
    end
  end

  assign bus.tx      = tx_line_r;
  assign bus.tx_busy = tx_busy_r;

  // ---------------------------------------------------------------- RX
  logic rx_sync1_r, rx_sync2_r, rx_prev_r;
  logic rx_fall_s;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection;
  // all reset to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_sync1_r <= 1'b1;
      rx_sync2_r <= 1'b1;
      rx_prev_r  <= 1'b1;
    end else begin
      rx_sync1_r <= bus.rx;
      rx_sync2_r <= rx_sync1_r;
      rx_prev_r  <= rx_sync2_r;
    end
  end

  assign rx_fall_s = rx_prev_r & ~rx_sync2_r;

  rx_state_e                  rx_state_r, rx_state_s;
  logic [TMR_W-1:0]           rx_tmr_r,   rx_tmr_s;
  logic [BIT_W-1:0]           rx_bit_r,   rx_bit_s;
  logic [FRAME_DATA_BITS-1:0] rx_shift_r, rx_shift_s;
  logic [FRAME_DATA_BITS-1:0] rx_data_r,  rx_data_s;
  logic                       rx_ready_r, rx_ready_s;
`ifdef UART_FRAME_ERR_EN
  logic                       frame_err_r, frame_err_s;
`endif

  // RX next state. The timer counts cycles since the falling edge was
  // registered: the start bit is checked at its midpoint, every later
  // sample follows DIV clocks after the previous one.
  always_comb begin
    rx_state_s = rx_state_r;
    rx_tmr_s   = rx_tmr_r + TMR_W'(1);
    rx_bit_s   = rx_bit_r;
    rx_shift_s = rx_shift_r;
    rx_data_s  = rx_data_r;
    rx_ready_s = 1'b0;
`ifdef UART_FRAME_ERR_EN
    frame_err_s = 1'b0;
`endif
    case (rx_state_r)
      RX_IDLE: begin
        rx_tmr_s = '0;
        if (rx_fall_s) begin
          rx_state_s = RX_START;
        end else begin
          rx_state_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_tmr_r == TMR_HALF) begin
          rx_tmr_s = '0;
          rx_bit_s = '0;
          // A high line at mid-start is a glitch: drop it silently.
          if (rx_sync2_r == 1'b0) begin
            rx_state_s = RX_DATA;
          end else begin
            rx_state_s = RX_IDLE;
          end
        end else begin
          rx_state_s = RX_START;
        end
      end
      RX_DATA: begin
        if (rx_tmr_r == TMR_FULL) begin
          rx_tmr_s   = '0;
          rx_shift_s = {rx_sync2_r, rx_shift_r[FRAME_DATA_BITS-1:1]};
          if (rx_bit_r == BIT_LAST) begin
            rx_state_s = RX_STOP;
          end else begin
            rx_bit_s   = rx_bit_r + BIT_W'(1);
          end
        end else begin
          rx_state_s = RX_DATA;
        end
      end
      RX_STOP: begin
        if (rx_tmr_r == TMR_FULL) begin
          rx_tmr_s   = '0;
          rx_state_s = RX_IDLE;
          if (rx_sync2_r == STOP_LEVEL) begin
            rx_data_s  = rx_shift_r;
            rx_ready_s = 1'b1;
          end else begin
`ifdef UART_FRAME_ERR_EN
            frame_err_s = 1'b1;
`else
            rx_data_s   = rx_data_r;
`endif
          end
        end else begin
          rx_state_s = RX_STOP;
        end
      end
      default: begin
        rx_state_s = RX_IDLE;
        rx_tmr_s   = '0;
      end
    endcase
  end

  // RX state, datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_r <= RX_IDLE;
      rx_tmr_r   <= '0;
      rx_bit_r   <= '0;
      rx_shift_r <= '0;
      rx_data_r  <= '0;
      rx_ready_r <= 1'b0;
    end else begin
      rx_state_r <= rx_state_s;
      rx_tmr_r   <= rx_tmr_s;
      rx_bit_r   <= rx_bit_s;
      rx_shift_r <= rx_shift_s;
      rx_data_r  <= rx_data_s;
      rx_ready_r <= rx_ready_s;
    end
  end

`ifdef UART_FRAME_ERR_EN
  // Frame-error pulse register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= frame_err_s;
    end
  end

  assign bus.rx_frame_err = frame_err_r;
`endif

  assign bus.rx_data   = rx_data_r;
  assign bus.rx_ready  = rx_ready_r;
  assign bus.baud_tick = tick_s;

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core -- directed self-checking bench for uart_core.
// Outputs are sampled and inputs driven on the falling clock edge.
// rx is either looped back from tx or driven directly by the bench.
module tb_uart_core;

  localparam int CLK_FREQ  = 100_000;
  localparam int BAUD_RATE = 9600;
  localparam int DIV       = 10;

  logic clk     = 1'b0;
  logic reset   = 1'b0;
  logic loop_en = 1'b0;
  logic rx_drv  = 1'b1;

  int checks    = 0;
  int passes    = 0;
  int rx_count  = 0;
  int err_count = 0;
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  uart_if bus();

  assign bus.rx = loop_en ? bus.tx : rx_drv;

  uart_core #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Collect every received byte.
  always @(negedge clk) begin
    if (bus.rx_ready === 1'b1) begin
      rx_count++;
      rx_q.push_back(bus.rx_data);
    end
  end

`ifdef UART_FRAME_ERR_EN
  // Count frame-error pulses.
  always @(negedge clk) begin
    if (bus.rx_frame_err === 1'b1) err_count++;
  end
`endif

  function automatic logic [7:0] byte_at(input int idx);
    if (idx < rx_q.size()) return rx_q[idx];
    return 8'hxx;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (bus.tx_busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) $display("FAIL send_wait: tx_busy=%b after %0d cycles, required 0", bus.tx_busy, n);
    else passes++;
    bus.tx_data = b;
    bus.tx_send = 1'b1;
    @(negedge clk);
    bus.tx_send = 1'b0;
  endtask

  task automatic wait_tx_low();
    int n;
    n = 0;
    while (bus.tx !== 1'b0 && n < 3*DIV) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.tx !== 1'b0) $display("FAIL start_edge: tx=%b, required 0 within %0d cycles", bus.tx, 3*DIV);
    else passes++;
  endtask

  task automatic wait_rx(input int target, input int limit);
    int n;
    n = 0;
    while (rx_count < target && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_drv = bits[k];
      repeat (DIV) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic check_rx(input string name, input int base, input int n_exp, input logic [7:0] b_exp);
    checks++;
    if (rx_count - base !== n_exp) $display("FAIL %s_count: got %0d bytes, required %0d", name, rx_count - base, n_exp);
    else passes++;
    checks++;
    if (byte_at(base) !== b_exp) $display("FAIL %s_byte: got %h, required %h", name, byte_at(base), b_exp);
    else passes++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.tx !== 1'b1) $display("FAIL rst_tx: got %b, required 1", bus.tx); else passes++;
    checks++; if (bus.tx_busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", bus.tx_busy); else passes++;
    checks++; if (bus.rx_data !== 8'h00) $display("FAIL rst_rx_data: got %h, required 00", bus.rx_data); else passes++;
    checks++; if (bus.rx_ready !== 1'b0) $display("FAIL rst_rx_ready: got %b, required 0", bus.rx_ready); else passes++;
    checks++; if (bus.baud_tick !== 1'b0) $display("FAIL rst_tick: got %b, required 0", bus.baud_tick); else passes++;
    reset = 1'b1;
  endtask

  task automatic test_baud_tick();
    int n;
    n = 0;
    while (bus.baud_tick !== 1'b1 && n < 2*DIV) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.baud_tick !== 1'b1) $display("FAIL tick_found: got %b, required 1", bus.baud_tick); else passes++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n = 1;
      checks++;
      if (bus.baud_tick !== 1'b0) $display("FAIL tick_width: got %b, required 0", bus.baud_tick); else passes++;
      while (bus.baud_tick !== 1'b1 && n < 3*DIV) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n !== DIV) $display("FAIL tick_period: got %0d, required %0d", n, DIV); else passes++;
    end
  endtask

  task automatic test_single_frame();
    int base, n;
    logic [9:0] frame;
    loop_en = 1'b1;
    base = rx_count;
    frame = {1'b1, 8'h56, 1'b0};
    send_byte(8'h56);
    checks++;
    if (bus.tx_busy !== 1'b1) $display("FAIL busy_set: got %b, required 1", bus.tx_busy); else passes++;
    wait_tx_low();
    repeat (DIV/2) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) repeat (DIV) @(negedge clk);
      checks++;
      if (bus.tx !== frame[k]) $display("FAIL tx_bit%0d: got %b, required %b", k, bus.tx, frame[k]); else passes++;
    end
    n = 0;
    while (bus.tx_busy !== 1'b0 && n < 3*DIV) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== DIV/2) $display("FAIL busy_clear: got %0d cycles after stop mid, required %0d", n, DIV/2); else passes++;
    wait_rx(base + 1, 10*DIV);
    repeat (3*DIV) @(negedge clk);
    check_rx("single", base, 1, 8'h56);
    checks++;
    if (bus.rx_data !== 8'h56) $display("FAIL single_rx_data: got %h, required 56", bus.rx_data); else passes++;
  endtask

  task automatic test_start_bit_width();
    int base, n;
    base = rx_count;
    send_byte(8'h41);
    wait_tx_low();
    n = 0;
    while (bus.tx === 1'b0 && n < 5*DIV) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== DIV) $display("FAIL start_width: got %0d, required %0d", n, DIV); else passes++;
    wait_rx(base + 1, 15*DIV);
    repeat (3*DIV) @(negedge clk);
    check_rx("start_width", base, 1, 8'h41);
  endtask

  task automatic test_ignored_send();
    int base;
    base = rx_count;
    send_byte(8'h56);
    repeat (2*DIV) @(negedge clk);
    bus.tx_data = 8'h41;
    bus.tx_send = 1'b1;
    @(negedge clk);
    bus.tx_send = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.tx_busy !== 1'b1) $display("FAIL ignore_busy: got %b, required 1", bus.tx_busy); else passes++;
    repeat (25*DIV) @(negedge clk);
    check_rx("ignore", base, 1, 8'h56);
  endtask

  task automatic test_back_to_back();
    int base;
    logic [7:0] vec [6];
    vec = '{8'h56, 8'h41, 8'h52, 8'h54, 8'h45, 8'h58};
    base = rx_count;
    for (int i = 0; i < 6; i++) send_byte(vec[i]);
    wait_rx(base + 6, 20*DIV);
    repeat (3*DIV) @(negedge clk);
    checks++;
    if (rx_count - base !== 6) $display("FAIL b2b_count: got %0d bytes, required 6", rx_count - base); else passes++;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (byte_at(base + i) !== vec[i]) $display("FAIL b2b_byte%0d: got %h, required %h", i, byte_at(base + i), vec[i]);
      else passes++;
    end
  endtask

  task automatic test_glitch();
    int base;
    loop_en = 1'b0;
    rx_drv = 1'b1;
    repeat (2*DIV) @(negedge clk);
    base = rx_count;
    rx_drv = 1'b0;
    repeat (DIV/4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (4*DIV) @(negedge clk);
    checks++;
    if (rx_count !== base) $display("FAIL glitch_count: got %0d bytes, required 0", rx_count - base); else passes++;
    drive_frame(8'hC3, 1'b1);
    repeat (3*DIV) @(negedge clk);
    check_rx("after_glitch", base, 1, 8'hC3);
  endtask

  task automatic test_frame_error();
    int base, ebase;
    base = rx_count;
    ebase = err_count;
    drive_frame(8'h55, 1'b0);
    repeat (3*DIV) @(negedge clk);
    checks++;
    if (rx_count !== base) $display("FAIL ferr_count: got %0d bytes, required 0", rx_count - base); else passes++;
    checks++;
    if (bus.rx_data !== 8'hC3) $display("FAIL ferr_rx_data: got %h, required c3", bus.rx_data); else passes++;
`ifdef UART_FRAME_ERR_EN
    checks++;
    if (err_count - ebase !== 1) $display("FAIL ferr_pulses: got %0d, required 1", err_count - ebase); else passes++;
`endif
  endtask

  task automatic test_reset_mid_frame();
    int base, n_low;
    loop_en = 1'b1;
    base = rx_count;
    send_byte(8'hA5);
    wait_tx_low();
    repeat (4*DIV + DIV/2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (bus.tx !== 1'b1) $display("FAIL mid_rst_tx: got %b, required 1", bus.tx); else passes++;
    checks++; if (bus.tx_busy !== 1'b0) $display("FAIL mid_rst_busy: got %b, required 0", bus.tx_busy); else passes++;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    n_low = 0;
    repeat (15*DIV) begin
      @(negedge clk);
      if (bus.tx !== 1'b1) n_low++;
    end
    checks++;
    if (n_low !== 0) $display("FAIL mid_rst_line: tx low for %0d cycles, required 0", n_low); else passes++;
    checks++;
    if (rx_count !== base) $display("FAIL mid_rst_rx: got %0d bytes, required 0", rx_count - base); else passes++;
    checks++;
    if (bus.rx_data !== 8'h00) $display("FAIL mid_rst_rx_data: got %h, required 00", bus.rx_data); else passes++;
    send_byte(8'h3C);
    wait_rx(base + 1, 20*DIV);
    repeat (3*DIV) @(negedge clk);
    check_rx("after_rst", base, 1, 8'h3C);
  endtask

  initial begin
    bus.tx_data = 8'h00;
    bus.tx_send = 1'b0;
    test_reset();
    test_baud_tick();
    test_single_frame();
    test_start_bit_width();
    test_ignored_send();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
